// File: rtl/imem_responder.sv
// imem_responder: direct-mapped, read-only instruction cache (8 lines x 4 words x 16 bits).
// Latency: hits answer combinationally in the request cycle; misses answer 1 cycle after the 4th memory beat.
// Backpressure: Stall is high while a line fill is in flight; requests presented then are ignored.
module imem_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic [15:0] addr_out,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  input  logic        mem_valid
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_valid;
  logic [9:0]  r_tag  [8];
  logic [15:0] r_data [8][4];
  logic [15:0] r_addr;
  logic [1:0]  r_k;

  logic [9:0]  w_tag;
  logic [2:0]  w_idx;
  logic [1:0]  w_off;
  logic [2:0]  w_lidx;
  logic [1:0]  w_loff;
  logic        w_legal;
  logic        w_hit;
  logic        w_miss;
  logic        w_beat;
  logic        w_unused_dump;

  // Debug dump request has no function in this block.
  assign w_unused_dump = createdump;

  assign w_tag   = Addr[15:6];
  assign w_idx   = Addr[5:3];
  assign w_off   = Addr[2:1];
  assign w_lidx  = r_addr[5:3];
  assign w_loff  = r_addr[2:1];
  assign w_legal = Rd && !Wr && !Addr[0];
  assign w_hit   = w_legal && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss  = (r_state == S_IDLE) && w_legal && !w_hit;
  assign w_beat  = (r_state == S_FILL) && mem_valid;

  // State register; reset returns to IDLE and aborts any fill in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Miss bookkeeping: latched request address, fill word counter and line valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_addr  <= '0;
      r_k     <= '0;
    end else if (w_miss) begin
      r_addr         <= Addr;
      r_k            <= 2'd0;
      r_valid[w_idx] <= 1'b0;   // line is being overwritten; only valid again once complete
    end else if (w_beat) begin
      r_k <= r_k + 2'd1;
      if (r_k == 2'd3) r_valid[w_lidx] <= 1'b1;
    end
  end

  // Tag/data arrays are written only by fills and are guarded by the valid bits, so no reset.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_data[w_lidx][r_k] <= mem_data;
      if (r_k == 2'd3) r_tag[w_lidx] <= r_addr[15:6];
    end
  end

  // Next state and all outputs; reset forces every output low without waiting for a clock.
  always_comb begin
    w_next   = r_state;
    DataOut  = 16'h0000;
    Done     = 1'b0;
    Stall    = 1'b0;
    CacheHit = 1'b0;
    err      = 1'b0;
    addr_out = 16'h0000;
    mem_addr = 16'h0000;
    mem_rd   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Rd) begin
          if (!w_legal) begin
            err = 1'b1;
          end else if (w_hit) begin
            Done     = 1'b1;
            CacheHit = 1'b1;
            DataOut  = r_data[w_idx][w_off];
            addr_out = Addr;
          end else begin
            w_next = S_FILL;
          end
        end else if (Wr) begin
          err = 1'b1;
        end
      end
      S_FILL: begin
        Stall    = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = {r_addr[15:3], r_k, 1'b0};
        if (w_beat && (r_k == 2'd3)) w_next = S_RESP;
      end
      S_RESP: begin
        Done     = 1'b1;
        DataOut  = r_data[w_lidx][w_loff];
        addr_out = r_addr;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (rst) begin
      DataOut  = 16'h0000;
      Done     = 1'b0;
      Stall    = 1'b0;
      CacheHit = 1'b0;
      err      = 1'b0;
      addr_out = 16'h0000;
      mem_addr = 16'h0000;
      mem_rd   = 1'b0;
    end
  end

endmodule
